req_pending_sched: RTL and testbench

- Upstream stage of the 4-bit registered priority encoder. Captures asynchronous request lines into sticky pending bits and drives them as the encoder's D input.
- Takes the encoder's Y/valid back, services one request at a time for a fixed number of cycles, then clears that request's pending bit.
- Encoder mapping used throughout: D bit i ↔ Y = 3−i. Bit 0 has highest priority; a 1-cycle encoder latency is designed in.

---
 rtl/req_pending_sched_pkg.sv | 31 +++
 rtl/req_pending_sched_sync.sv | 34 +++
 rtl/req_pending_sched.sv | 130 +++++++++++++
 tb/tb_req_pending_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_pending_sched_pkg.sv
// Shared types and helpers for the request-pending scheduler.
package req_pending_sched_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    SERVICE = 2'd2,
    CLEAR   = 2'd3
  } sched_state_e;

  // Encoder Y code to D bit index (bit 0 is the highest priority, Y = 3).
  function automatic logic [1:0] idx_from_y(input logic [1:0] y);
    return 2'd3 - y;
  endfunction

  // One-hot pending mask for the bit that a given Y code refers to.
  function automatic logic [NUM_REQ-1:0] onehot_from_y(input logic [1:0] y);
    logic [NUM_REQ-1:0] m;
    m = 4'b0000;
    m[idx_from_y(y)] = 1'b1;
    return m;
  endfunction

  // Number of set bits in a request vector.
  function automatic logic [2:0] popcount4(input logic [NUM_REQ-1:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/req_pending_sched_sync.sv
// Per-bit synchronizer chain followed by a rising-edge detector.
module req_sync_edge
  import req_pending_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] rise
);

  logic [NUM_REQ-1:0] sync_r [SYNC_STAGES];
  logic [NUM_REQ-1:0] prev_r;

  // Shift asynchronous requests through the chain and keep the previous synced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 4'b0000;
      end
      prev_r <= 4'b0000;
    end else begin
      sync_r[0] <= req_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/req_pending_sched.sv
// Sticky request capture feeding a priority encoder, with one-at-a-time
// fixed-length service of the encoded request.
module req_pending_sched
  import req_pending_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SVC_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [1:0]         enc_y,
  input  logic               enc_valid,
  output logic [NUM_REQ-1:0] enc_d,
  output logic               svc_busy,
  output logic [1:0]         svc_id,
  output logic               svc_done,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               err
);

  localparam logic [7:0]       SVC_LOAD = 8'(SVC_CYCLES - 1);
  localparam logic [CNT_W+2:0] DROP_MAX = {3'b000, {CNT_W{1'b1}}};

  logic [NUM_REQ-1:0] rise_s;
  sched_state_e       state_r, state_s;
  logic [7:0]         cnt_r, cnt_s;
  logic [NUM_REQ-1:0] enc_d_r, enc_d_s;
  logic [1:0]         svc_id_r, svc_id_s;
  logic [CNT_W-1:0]   drop_cnt_r, drop_cnt_s;
  logic               err_r, err_s;
  logic               svc_busy_r, svc_done_r;
  logic [NUM_REQ-1:0] clr_mask_s;
  logic [NUM_REQ-1:0] drop_bits_s;
  logic [CNT_W+2:0]   drop_sum_s;

  req_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .req_in (req_in),
    .rise   (rise_s)
  );

  // Scheduler next state: wait one cycle for the encoder, pick, service, clear.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    svc_id_s   = svc_id_r;
    err_s      = err_r;
    clr_mask_s = 4'b0000;
    case (state_r)
      IDLE: begin
        if (enc_d_r != 4'b0000) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (enc_valid && enc_d_r[idx_from_y(enc_y)]) begin
          svc_id_s = enc_y;
          cnt_s    = SVC_LOAD;
          state_s  = SERVICE;
        end else begin
          err_s   = 1'b1;
          state_s = IDLE;
        end
      end
      SERVICE: begin
        if (cnt_r == 8'd0) begin
          state_s = CLEAR;
        end else begin
          cnt_s   = cnt_r - 8'd1;
          state_s = SERVICE;
        end
      end
      CLEAR: begin
        clr_mask_s = onehot_from_y(svc_id_r);
        state_s    = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pending merge (set beats clear) and saturating count of redundant rises.
  always_comb begin
    enc_d_s     = (enc_d_r & ~clr_mask_s) | rise_s;
    drop_bits_s = rise_s & enc_d_r & ~clr_mask_s;
    drop_sum_s  = {3'b000, drop_cnt_r} + {{CNT_W{1'b0}}, popcount4(drop_bits_s)};
    if (drop_sum_s > DROP_MAX) begin
      drop_cnt_s = {CNT_W{1'b1}};
    end else begin
      drop_cnt_s = drop_sum_s[CNT_W-1:0];
    end
  end

  // State, pending bits, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      enc_d_r    <= 4'b0000;
      svc_id_r   <= 2'd0;
      drop_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
      svc_busy_r <= 1'b0;
      svc_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      enc_d_r    <= enc_d_s;
      svc_id_r   <= svc_id_s;
      drop_cnt_r <= drop_cnt_s;
      err_r      <= err_s;
      svc_busy_r <= (state_s == SERVICE);
      svc_done_r <= (state_s == CLEAR);
    end
  end

  assign enc_d    = enc_d_r;
  assign svc_busy = svc_busy_r;
  assign svc_id   = svc_id_r;
  assign svc_done = svc_done_r;
  assign drop_cnt = drop_cnt_r;
  assign err      = err_r;

endmodule

// File: tb/tb_req_pending_sched.sv
// Directed bench for req_pending_sched with a behavioural registered
// priority encoder closing the enc_d -> enc_y/enc_valid loop.
module tb_req_pending_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [1:0] enc_y;
  logic       enc_valid;
  logic [3:0] enc_d;
  logic       svc_busy;
  logic [1:0] svc_id;
  logic       svc_done;
  logic [1:0] drop_cnt;
  logic       err;

  logic [1:0] model_y;
  logic       model_valid;
  logic       force_inv;

  int total;
  int bad;
  int cyc;

  req_pending_sched #(.SYNC_STAGES(2), .SVC_CYCLES(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .enc_y     (enc_y),
    .enc_valid (enc_valid),
    .enc_d     (enc_d),
    .svc_busy  (svc_busy),
    .svc_id    (svc_id),
    .svc_done  (svc_done),
    .drop_cnt  (drop_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered 4-bit priority encoder: bit 0 highest, Y = 3 - index.
  always @(posedge clk) begin
    if (rst) begin
      model_y     <= 2'd0;
      model_valid <= 1'b0;
    end else begin
      model_valid <= |enc_d;
      if (enc_d[0])      model_y <= 2'd3;
      else if (enc_d[1]) model_y <= 2'd2;
      else if (enc_d[2]) model_y <= 2'd1;
      else if (enc_d[3]) model_y <= 2'd0;
      else               model_y <= 2'd0;
    end
  end

  assign enc_y     = model_y;
  assign enc_valid = model_valid & ~force_inv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a service to start, check its id and length, end on the done pulse.
  task automatic svc_check(input string tag, input logic [1:0] exp_id, output int done_cyc);
    int n;
    n = 0;
    while (svc_busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, svc_busy, 1);
    chk({tag, "_id"}, svc_id, exp_id);
    n = 0;
    while (svc_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_len"}, n, 4);
    chk({tag, "_done"}, svc_done, 1);
    chk({tag, "_idhold"}, svc_id, exp_id);
    done_cyc = cyc;
  endtask

  initial begin
    int d1;
    int d2;
    int n;
    logic seen;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    force_inv = 1'b0;

    // Test 1: reset with req_in[2] held high.
    rst    = 1'b1;
    req_in = 4'b0100;
    tick();
    tick();
    chk("rst_enc_d", enc_d, 4'b0000);
    chk("rst_busy", svc_busy, 0);
    chk("rst_done", svc_done, 0);
    chk("rst_id", svc_id, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("t1_pend_early", enc_d, 4'b0000);
    tick();
    chk("t1_pend", enc_d, 4'b0100);
    req_in = 4'b0000;
    tick();
    chk("t1_wait_busy", svc_busy, 0);
    tick();
    chk("t1_busy_rise", svc_busy, 1);
    chk("t1_id", svc_id, 1);
    tick();
    tick();
    tick();
    chk("t1_busy_last", svc_busy, 1);
    tick();
    chk("t1_busy_fall", svc_busy, 0);
    chk("t1_done", svc_done, 1);
    chk("t1_pend_in_clear", enc_d, 4'b0100);
    tick();
    chk("t1_done_pulse", svc_done, 0);
    chk("t1_cleared", enc_d, 4'b0000);
    chk("t1_drop", drop_cnt, 0);

    // Test 2: two simultaneous requests serviced by priority.
    req_in = 4'b1010;
    tick();
    req_in = 4'b0000;
    svc_check("t2a", 2'd2, d1);
    svc_check("t2b", 2'd0, d2);
    chk("t2_gap", d2 - d1, 7);
    tick();
    chk("t2_final", enc_d, 4'b0000);

    // Test 3: bit 0 arrives during bit-3 service; bit 3 re-rises while in service.
    req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    n = 0;
    while (svc_busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t3_start", svc_busy, 1);
    chk("t3_id", svc_id, 0);
    req_in = 4'b1001;
    n = 1;
    tick();
    req_in = 4'b0000;
    while (svc_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("t3_len", n, 4);
    chk("t3_done", svc_done, 1);
    chk("t3_drop", drop_cnt, 1);
    svc_check("t3b", 2'd3, d1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | svc_busy;
    end
    chk("t3_no_reservice", seen, 0);
    chk("t3_final", enc_d, 4'b0000);

    // Test 4: bit-2 rise lands on its own clear edge.
    req_in = 4'b0100;
    tick();
    req_in = 4'b0000;
    n = 0;
    while (svc_busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_id", svc_id, 1);
    tick();
    tick();
    req_in = 4'b0100;
    tick();
    req_in = 4'b0000;
    tick();
    chk("t4_done", svc_done, 1);
    tick();
    chk("t4_pend_kept", enc_d, 4'b0100);
    chk("t4_drop", drop_cnt, 1);
    svc_check("t4b", 2'd1, d1);
    tick();
    chk("t4_final", enc_d, 4'b0000);

    // Test 5: one-cycle reset in the middle of a service.
    req_in = 4'b0010;
    tick();
    req_in = 4'b0000;
    n = 0;
    while (svc_busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_start", svc_busy, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", svc_busy, 0);
    chk("t5_done", svc_done, 0);
    chk("t5_enc_d", enc_d, 4'b0000);
    chk("t5_id", svc_id, 0);
    chk("t5_drop", drop_cnt, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | svc_busy | svc_done;
    end
    chk("t5_quiet", seen, 0);

    // Test 6: five redundant rises on pending bit 3 saturate a 2-bit counter.
    req_in = 4'b1001;
    tick();
    req_in = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_in = 4'b1000;
      tick();
      req_in = 4'b0000;
      tick();
    end
    tick();
    tick();
    chk("t6_sat", drop_cnt, 3);
    n = 0;
    while (enc_d !== 4'b0000 && n < 60) begin
      tick();
      n++;
    end
    chk("t6_drained", enc_d, 4'b0000);
    chk("t6_sat_hold", drop_cnt, 3);
    chk("t6_err", err, 0);

    // Test 7: encoder reports invalid in WAIT; err is sticky until reset.
    force_inv = 1'b1;
    req_in    = 4'b0100;
    tick();
    req_in = 4'b0000;
    for (int i = 0; i < 8; i++) tick();
    chk("t7_err", err, 1);
    chk("t7_no_busy", svc_busy, 0);
    chk("t7_pend", enc_d, 4'b0100);
    force_inv = 1'b0;
    svc_check("t7b", 2'd1, d1);
    chk("t7_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_err_rst", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
